// File: rtl/rtl_handshake_pkg.sv
// Purpose: shared types and default geometry for the handshake driver slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rtl_handshake_pkg;

  localparam int WIDTH_DEF     = 5;
  localparam int DEPTH_DEF     = 4;
  localparam int NUM_LANES_DEF = 3;
  localparam int TIMEOUT_DEF   = 15;

  // Lane tag width; a single-lane build still carries a 1-bit tag.
  function automatic int lane_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int LANE_W_DEF = lane_bits(NUM_LANES_DEF);

  // FIFO entry at the default geometry.
  typedef struct packed {
    logic [LANE_W_DEF-1:0] lane;
    logic [WIDTH_DEF-1:0]  data;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    DROP    = 2'd2
  } drv_state_e;

endpackage

// File: rtl/rtl_handshake_fifo.sv
// Purpose: synchronous FIFO holding tagged words; exposes head and the entry behind it.
// Latency: a pushed word is readable at the head one cycle after the push edge.
// Backpressure: caller must not push when full or pop when empty; count is registered.
// Ports: clk/reset (sync, active-high), push/push_dat, pop, head_dat, second_dat, count.
module rtl_handshake_fifo #(
  parameter  int DW    = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [DW-1:0]    push_dat,
  input  logic             pop,
  output logic [DW-1:0]    head_dat,
  output logic [DW-1:0]    second_dat,
  output logic [CNT_W-1:0] count
);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DW-1:0]    mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_dat;
    end
    // Pointers wrap naturally because DEPTH is a power of two.
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Storage carries no reset; emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
  assign head_dat   = mem_q[rd_ptr_q];
  assign second_dat = mem_q[rd_ptr_nxt];
  assign count      = count_q;

endmodule

// File: rtl/rtl_handshake_driver.sv
// Purpose: buffers tagged words and drives them on one of NUM_LANES ready/valid lanes.
// Latency: word loaded at edge N is presented from cycle N+1; transfer at N+1 with ready high.
// Backpressure: valid/data held until the selected lane's ready; load_ready = count < DEPTH.
// Ports: CLK, RESET (sync, active-high); load_valid/load_ready/load_data/load_lane in;
//        handshake_valid/handshake_ready/out_data out; count, stall_err, sent_total status.
module rtl_handshake_driver
  import rtl_handshake_pkg::*;
#(
  parameter  int WIDTH     = WIDTH_DEF,
  parameter  int DEPTH     = DEPTH_DEF,
  parameter  int NUM_LANES = NUM_LANES_DEF,
  parameter  int TIMEOUT   = TIMEOUT_DEF,
  localparam int LANE_W    = lane_bits(NUM_LANES),
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [WIDTH-1:0]     load_data,
  input  logic [LANE_W-1:0]    load_lane,
  output logic [NUM_LANES-1:0] handshake_valid,
  input  logic [NUM_LANES-1:0] handshake_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [CNT_W-1:0]     count,
  output logic                 stall_err,
  output logic [7:0]           sent_total
);

  // Same layout as entry_t, but sized from this instance's parameters.
  typedef struct packed {
    logic [LANE_W-1:0] lane;
    logic [WIDTH-1:0]  data;
  } lane_entry_t;

  localparam int EW = $bits(lane_entry_t);

  lane_entry_t          push_ent, head_ent, second_ent, next_head;
  logic                 push, pop, xfer;
  logic [CNT_W-1:0]     fifo_count, count_next;

  drv_state_e           state_q, state_d;
  logic [NUM_LANES-1:0] valid_q, valid_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [7:0]           stall_q, stall_d;
  logic                 err_q, err_d;
  logic [7:0]           sent_q, sent_d;

  // Ready is registered-only: a full FIFO refuses loads even if the head pops this cycle.
  assign load_ready = (fifo_count < CNT_W'(DEPTH));
  assign push       = load_valid && load_ready;
  assign push_ent   = '{lane: load_lane, data: load_data};

  // valid_q has at most one bit set, so ready on other lanes cannot cause a transfer.
  assign xfer = |(valid_q & handshake_ready);
  // An illegal-lane head leaves unconditionally during its single DROP cycle.
  assign pop  = xfer || (state_q == DROP);

  rtl_handshake_fifo #(
    .DW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (CLK),
    .reset      (RESET),
    .push       (push),
    .push_dat   (push_ent),
    .pop        (pop),
    .head_dat   (head_ent),
    .second_dat (second_ent),
    .count      (fifo_count)
  );

  always_comb begin
    count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);

    // Entry that will sit at the head after this edge. When the FIFO holds at most
    // one word that is leaving, the new head is the word being loaded right now.
    if (!pop) begin
      next_head = (fifo_count == '0) ? push_ent : head_ent;
    end else begin
      next_head = (fifo_count == CNT_W'(1)) ? push_ent : second_ent;
    end

    if (count_next == '0) begin
      state_d = IDLE;
    end else if (32'(next_head.lane) < NUM_LANES) begin
      state_d = PRESENT;
    end else begin
      state_d = DROP;
    end

    // Outputs are precomputed from the next head so they come straight from flops.
    valid_d = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      valid_d[i] = (state_d == PRESENT) && (32'(next_head.lane) == i);
    end
    data_d = (state_d == PRESENT) ? next_head.data : '0;

    if ((state_q == PRESENT) && !xfer) begin
      stall_d = (stall_q < 8'(TIMEOUT)) ? stall_q + 8'd1 : stall_q;
    end else begin
      stall_d = '0;
    end
    err_d  = err_q | (stall_d == 8'(TIMEOUT));
    sent_d = sent_q + 8'(xfer);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      valid_q <= '0;
      data_q  <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      stall_q <= stall_d;
      err_q   <= err_d;
      sent_q  <= sent_d;
    end
  end

  assign handshake_valid = valid_q;
  assign out_data        = data_q;
  assign count           = fifo_count;
  assign stall_err       = err_q;
  assign sent_total      = sent_q;

endmodule

// File: tb/tb_rtl_handshake_driver.sv
// Purpose: self-checking bench for rtl_handshake_driver (queue model plus directed literals).
// Latency: n/a.
// Backpressure: lane ready driven directly by the directed sequences.
module tb_rtl_handshake_driver;
  import rtl_handshake_pkg::*;

  localparam int TO  = TIMEOUT_DEF;
  localparam int DEP = DEPTH_DEF;
  localparam int NL  = NUM_LANES_DEF;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       load_valid;
  logic       load_ready;
  logic [4:0] load_data;
  logic [1:0] load_lane;
  logic [2:0] hv;
  logic [2:0] hr;
  logic [4:0] out_data;
  logic [2:0] count;
  logic       stall_err;
  logic [7:0] sent_total;

  rtl_handshake_driver dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .load_valid      (load_valid),
    .load_ready      (load_ready),
    .load_data       (load_data),
    .load_lane       (load_lane),
    .handshake_valid (hv),
    .handshake_ready (hr),
    .out_data        (out_data),
    .count           (count),
    .stall_err       (stall_err),
    .sent_total      (sent_total)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic offer(input logic [1:0] lane, input logic [4:0] data);
    load_valid = 1'b1;
    load_lane  = lane;
    load_data  = data;
  endtask

  // Behavioural model: a queue of accepted words; the head is on the wire whenever the
  // queue is non-empty and its lane is legal, and an illegal head leaves at the next edge.
  entry_t mq[$];
  int     m_sent  = 0;
  int     m_stall = 0;
  bit     m_err   = 1'b0;

  always @(posedge CLK) begin
    int sz;
    if (RESET) begin
      mq.delete();
      m_sent  = 0;
      m_stall = 0;
      m_err   = 1'b0;
    end else begin
      sz = mq.size();
      if (sz > 0) begin
        if (int'(mq[0].lane) >= NL) begin
          void'(mq.pop_front());
          m_stall = 0;
        end else if (hr[mq[0].lane]) begin
          void'(mq.pop_front());
          m_sent  = (m_sent + 1) % 256;
          m_stall = 0;
        end else begin
          if (m_stall < TO) m_stall++;
          if (m_stall == TO) m_err = 1'b1;
        end
      end
      if (load_valid && sz < DEP) begin
        mq.push_back('{lane: load_lane, data: load_data});
      end
    end
  end

  always @(negedge CLK) begin
    logic [2:0] ev;
    if (chk_en) begin
      ev = '0;
      if (mq.size() > 0 && int'(mq[0].lane) < NL) ev[mq[0].lane] = 1'b1;
      check("m_count",      32'(count),      32'(mq.size()));
      check("m_load_ready", 32'(load_ready), 32'(mq.size() < DEP));
      check("m_valid",      32'(hv),         32'(ev));
      if (ev != 3'b000) check("m_out_data", 32'(out_data), 32'(mq[0].data));
      check("m_stall_err",  32'(stall_err),  32'(m_err));
      check("m_sent_total", 32'(sent_total), 32'(m_sent));
    end
  end

  initial begin
    logic [4:0] got[$];

    RESET = 1'b1; load_valid = 1'b0; load_data = '0; load_lane = '0; hr = '0;
    tick; tick;
    check("rst_valid",      32'(hv),         32'h0);
    check("rst_out_data",   32'(out_data),   32'h0);
    check("rst_count",      32'(count),      32'h0);
    check("rst_load_ready", 32'(load_ready), 32'h1);
    check("rst_stall_err",  32'(stall_err),  32'h0);
    check("rst_sent_total", 32'(sent_total), 32'h0);
    chk_en = 1'b1;
    RESET  = 1'b0;
    tick;

    // Back-to-back words on three lanes with every ready high.
    hr = 3'b111;
    offer(2'd0, 5'h05); tick;
    check("t1_valid0", 32'(hv), 32'b001); check("t1_data0", 32'(out_data), 32'h05);
    offer(2'd2, 5'h1F); tick;
    check("t1_valid1", 32'(hv), 32'b100); check("t1_data1", 32'(out_data), 32'h1F);
    offer(2'd1, 5'h0A); tick;
    check("t1_valid2", 32'(hv), 32'b010); check("t1_data2", 32'(out_data), 32'h0A);
    load_valid = 1'b0; tick;
    check("t1_sent", 32'(sent_total), 32'd3);
    check("t1_count", 32'(count), 32'd0);

    // Fill with ready low, offer one more while full, then drain.
    hr = 3'b000;
    for (int i = 0; i < 4; i++) begin
      offer(2'(i % 3), 5'(i + 1)); tick;
    end
    check("t2_full_count", 32'(count), 32'd4);
    check("t2_full_ready", 32'(load_ready), 32'd0);
    offer(2'd1, 5'h15); tick;
    check("t2_reject_count", 32'(count), 32'd4);
    load_valid = 1'b0;
    hr = 3'b111;
    for (int c = 0; c < 20 && count != 3'd0; c++) begin
      if (hv != 3'b000) got.push_back(out_data);
      tick;
    end
    check("t2_drain_done", 32'(count), 32'd0);
    check("t2_drain_n", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) check("t2_drain_order", 32'(got[i]), 32'(i + 1));
    check("t2_sent", 32'(sent_total), 32'd7);

    // Ready on a lane other than the head's must be ignored.
    hr = 3'b000;
    offer(2'd2, 5'h07); tick;
    load_valid = 1'b0;
    hr = 3'b001;
    tick; tick; tick;
    check("t4_count", 32'(count), 32'd1);
    check("t4_valid", 32'(hv), 32'b100);
    check("t4_data", 32'(out_data), 32'h07);
    hr = 3'b100; tick;
    check("t4_pop_count", 32'(count), 32'd0);
    check("t4_sent", 32'(sent_total), 32'd8);

    // Illegal lane tag is dropped with one bubble, then lane 0 presents.
    hr = 3'b111;
    offer(2'd3, 5'h11); tick;
    check("t5_bubble_valid", 32'(hv), 32'b000);
    check("t5_bubble_count", 32'(count), 32'd1);
    offer(2'd0, 5'h09); tick;
    load_valid = 1'b0;
    check("t5_valid", 32'(hv), 32'b001);
    check("t5_data", 32'(out_data), 32'h09);
    tick;
    check("t5_sent", 32'(sent_total), 32'd9);

    // Stall on lane 1 for TIMEOUT cycles.
    hr = 3'b000;
    offer(2'd1, 5'h0C); tick;
    load_valid = 1'b0;
    check("t3_valid_rise", 32'(hv), 32'b010);
    for (int k = 1; k < TO; k++) begin
      tick;
      check("t3_hold_valid", 32'(hv), 32'b010);
      check("t3_hold_data", 32'(out_data), 32'h0C);
      check("t3_no_err_yet", 32'(stall_err), 32'd0);
    end
    tick;
    check("t3_err_rise", 32'(stall_err), 32'd1);
    check("t3_still_valid", 32'(hv), 32'b010);
    hr = 3'b010; tick;
    check("t3_done_count", 32'(count), 32'd0);
    check("t3_sent", 32'(sent_total), 32'd10);
    check("t3_err_sticky", 32'(stall_err), 32'd1);

    // Reset in the middle of a stall with two words queued.
    hr = 3'b000;
    offer(2'd0, 5'h01); tick;
    offer(2'd1, 5'h02); tick;
    load_valid = 1'b0;
    tick; tick;
    check("t6_pre_count", 32'(count), 32'd2);
    RESET = 1'b1; tick;
    check("t6_valid", 32'(hv), 32'h0);
    check("t6_out_data", 32'(out_data), 32'h0);
    check("t6_count", 32'(count), 32'h0);
    check("t6_load_ready", 32'(load_ready), 32'h1);
    check("t6_stall_err", 32'(stall_err), 32'h0);
    check("t6_sent_total", 32'(sent_total), 32'h0);
    RESET = 1'b0; tick;
    check("t6_idle_valid", 32'(hv), 32'h0);
    tick;

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
